// File: rtl/vga_frame_reader.sv
// vga_frame_reader: 640x480@60 VGA timing generator and 2x-scaled frame-buffer reader.
// The counter state is flagged, a BRAM address is issued one cycle later, and the
// flags travel alongside the read so colour and sync leave together PIPE cycles
// after the counter state. mem_data is captured on the MEM_LAT-th clock edge after
// the edge that launched mem_addr.
module vga_frame_reader #(
  parameter int          H_VISIBLE = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_VISIBLE = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter int          IMG_W     = 320,
  parameter int          IMG_H     = 240,
  parameter int          MEM_LAT   = 2,
  parameter int          ADDR_W    = 17,
  parameter logic [23:0] BG_COLOR  = 24'h000000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [23:0]       mem_data,
  output logic              hsync,
  output logic              vsync,
  output logic              visible,
  output logic [23:0]       data_out,
  output logic              frame_start,
  output logic [9:0]        hcount,
  output logic [9:0]        vcount
);

  localparam int HT     = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int VT     = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG = H_VISIBLE + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_VISIBLE + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC;

  // The stored image must fit in the frame-buffer address space.
  generate
    if (IMG_W * IMG_H > (1 << ADDR_W)) begin : g_cfg_check
      $error("vga_frame_reader: IMG_W*IMG_H exceeds the 2^ADDR_W frame buffer");
    end
    if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_lat_check
      $error("vga_frame_reader: MEM_LAT must be in 1..4");
    end
  endgenerate

  logic [9:0]        r_hc;
  logic [9:0]        r_vc;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_rd_en;

  // Flag pipeline stages 0..MEM_LAT-1; the output register is the final stage.
  logic [MEM_LAT-1:0] r_vis_p;
  logic [MEM_LAT-1:0] r_hs_p;
  logic [MEM_LAT-1:0] r_vs_p;
  logic [MEM_LAT-1:0] r_img_p;
  logic [MEM_LAT-1:0] r_fs_p;

  logic              r_hsync;
  logic              r_vsync;
  logic              r_visible;
  logic              r_frame_start;
  logic [23:0]       r_data_out;

  logic              w_h_wrap;
  logic              w_v_wrap;
  logic              w_vis;
  logic              w_hs;
  logic              w_vs;
  logic              w_img;
  logic              w_img_row;
  logic              w_fs;
  logic [8:0]        w_col;

  assign w_h_wrap  = (r_hc == 10'(HT - 1));
  assign w_v_wrap  = (r_vc == 10'(VT - 1));
  assign w_vis     = (int'(r_hc) < H_VISIBLE) && (int'(r_vc) < V_VISIBLE);
  assign w_hs      = !((int'(r_hc) >= HS_BEG) && (int'(r_hc) < HS_END));
  assign w_vs      = !((int'(r_vc) >= VS_BEG) && (int'(r_vc) < VS_END));
  assign w_img_row = (int'(r_vc) < 2 * IMG_H);
  assign w_img     = (int'(r_hc) < 2 * IMG_W) && w_img_row;
  assign w_fs      = (r_hc == 10'd0) && (r_vc == 10'd0);
  assign w_col     = r_hc[9:1];

  // Raw horizontal/vertical counters; vc advances on every hc wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (w_h_wrap) begin
      r_hc <= '0;
      r_vc <= w_v_wrap ? 10'd0 : r_vc + 10'd1;
    end else begin
      r_hc <= r_hc + 10'd1;
    end
  end

  // Row base steps by one stored line after every second image line (2x vertical scale).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row_base <= '0;
    end else if (w_h_wrap) begin
      if (w_v_wrap)
        r_row_base <= '0;
      else if (r_vc[0] && w_img_row)
        r_row_base <= r_row_base + ADDR_W'(IMG_W);
    end
  end

  // Stage 1: registered read address and strobe; address holds outside the image.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_addr  <= '0;
      r_mem_rd_en <= 1'b0;
    end else begin
      r_mem_rd_en <= w_img;
      if (w_img)
        r_mem_addr <= r_row_base + ADDR_W'(w_col);
    end
  end

  // Flag shift registers covering the address stage plus BRAM latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vis_p <= '0;
      r_hs_p  <= '1;
      r_vs_p  <= '1;
      r_img_p <= '0;
      r_fs_p  <= '0;
    end else begin
      r_vis_p[0] <= w_vis;
      r_hs_p[0]  <= w_hs;
      r_vs_p[0]  <= w_vs;
      r_img_p[0] <= w_img;
      r_fs_p[0]  <= w_fs;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_vis_p[i] <= r_vis_p[i-1];
        r_hs_p[i]  <= r_hs_p[i-1];
        r_vs_p[i]  <= r_vs_p[i-1];
        r_img_p[i] <= r_img_p[i-1];
        r_fs_p[i]  <= r_fs_p[i-1];
      end
    end
  end

  // Final stage: colour select registered together with the delayed flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_visible     <= 1'b0;
      r_frame_start <= 1'b0;
      r_data_out    <= '0;
    end else begin
      r_hsync       <= r_hs_p[MEM_LAT-1];
      r_vsync       <= r_vs_p[MEM_LAT-1];
      r_visible     <= r_vis_p[MEM_LAT-1];
      r_frame_start <= r_fs_p[MEM_LAT-1];
      if (!r_vis_p[MEM_LAT-1])
        r_data_out <= '0;
      else if (r_img_p[MEM_LAT-1])
        r_data_out <= mem_data;
      else
        r_data_out <= BG_COLOR;
    end
  end

  assign mem_addr    = r_mem_addr;
  assign mem_rd_en   = r_mem_rd_en;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign visible     = r_visible;
  assign data_out    = r_data_out;
  assign frame_start = r_frame_start;
  assign hcount      = r_hc;
  assign vcount      = r_vc;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: full-size timing instance, a reduced-timing instance
// for whole-frame and mid-frame-reset coverage, and a reduced instance with a
// background colour. A position-based model predicts every output each cycle.
module tb_vga_frame_reader;

  localparam int PIPE = 3;

  typedef struct packed {
    int hv; int hf; int hs; int hb;
    int vv; int vf; int vs; int vb;
    int iw; int ih;
    logic [23:0] bg;
  } cfg_t;

  localparam cfg_t C_D = '{640, 16, 96, 48, 480, 10, 2, 33, 320, 240, 24'h000000};
  localparam cfg_t C_S = '{16, 2, 4, 2, 12, 1, 2, 1, 8, 6, 24'h000000};
  localparam cfg_t C_B = '{16, 2, 4, 2, 12, 1, 2, 1, 5, 4, 24'h00FF00};

  logic clk;
  logic rst_n;
  logic rst_s;
  int   checks;
  int   errors;
  logic run;

  logic [16:0] ma_d, ma_s, ma_b;
  logic        re_d, re_s, re_b;
  logic [23:0] md_d, md_s, md_b;
  logic        hs_d, hs_s, hs_b, vs_d, vs_s, vs_b;
  logic        vis_d, vis_s, vis_b, fs_d, fs_s, fs_b;
  logic [23:0] do_d, do_s, do_b;
  logic [9:0]  hc_d, hc_s, hc_b, vc_d, vc_s, vc_b;

  int e_d, e_s;
  int last_d, last_s, last_b;

  vga_frame_reader u_dflt (
    .clk(clk), .rst(rst_n), .mem_addr(ma_d), .mem_rd_en(re_d), .mem_data(md_d),
    .hsync(hs_d), .vsync(vs_d), .visible(vis_d), .data_out(do_d),
    .frame_start(fs_d), .hcount(hc_d), .vcount(vc_d)
  );

  vga_frame_reader #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_VISIBLE(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .IMG_W(8), .IMG_H(6)
  ) u_small (
    .clk(clk), .rst(rst_s), .mem_addr(ma_s), .mem_rd_en(re_s), .mem_data(md_s),
    .hsync(hs_s), .vsync(vs_s), .visible(vis_s), .data_out(do_s),
    .frame_start(fs_s), .hcount(hc_s), .vcount(vc_s)
  );

  vga_frame_reader #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_VISIBLE(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .IMG_W(5), .IMG_H(4), .BG_COLOR(24'h00FF00)
  ) u_bg (
    .clk(clk), .rst(rst_n), .mem_addr(ma_b), .mem_rd_en(re_b), .mem_data(md_b),
    .hsync(hs_b), .vsync(vs_b), .visible(vis_b), .data_out(do_b),
    .frame_start(fs_b), .hcount(hc_b), .vcount(vc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM models returning {7'b0, addr}; one internal register stage for MEM_LAT = 2.
  always @(posedge clk) begin
    md_d <= {7'b0, ma_d};
    md_s <= {7'b0, ma_s};
    md_b <= {7'b0, ma_b};
  end

  // Edges seen since each reset was released.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) e_d <= 0; else e_d <= e_d + 1;
  always @(posedge clk or negedge rst_s)
    if (!rst_s) e_s <= 0; else e_s <= e_s + 1;

  function automatic int ht(input cfg_t c); return c.hv + c.hf + c.hs + c.hb; endfunction
  function automatic int vt(input cfg_t c); return c.vv + c.vf + c.vs + c.vb; endfunction
  function automatic int hpos(input cfg_t c, input int k); return k % ht(c); endfunction
  function automatic int vpos(input cfg_t c, input int k); return (k / ht(c)) % vt(c); endfunction

  function automatic logic img_at(input cfg_t c, input int k);
    return (hpos(c, k) < 2 * c.iw) && (vpos(c, k) < 2 * c.ih);
  endfunction

  function automatic int addr_at(input cfg_t c, input int k);
    return (vpos(c, k) / 2) * c.iw + hpos(c, k) / 2;
  endfunction

  task automatic cmp(input string nm, input string sig, input int e,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s edge %0d: got %h want %h", nm, sig, e, act, exp);
    end
  endtask

  task automatic check_dut(input string nm, input cfg_t c, input int e, inout int last,
                           input logic hs_a, input logic vs_a, input logic vis_a,
                           input logic fs_a, input logic [23:0] d_a,
                           input logic [16:0] ma_a, input logic re_a,
                           input logic [9:0] hc_a, input logic [9:0] vc_a);
    int k, km, h, v;
    logic xv, xh, xs, xf, xr;
    logic [23:0] xd;
    k  = e - PIPE;
    xv = 1'b0; xh = 1'b1; xs = 1'b1; xf = 1'b0; xd = 24'd0;
    if (k >= 0) begin
      h  = hpos(c, k);
      v  = vpos(c, k);
      xv = (h < c.hv) && (v < c.vv);
      xh = !((h >= c.hv + c.hf) && (h < c.hv + c.hf + c.hs));
      xs = !((v >= c.vv + c.vf) && (v < c.vv + c.vf + c.vs));
      xf = (k % (ht(c) * vt(c))) == 0;
      if (xv) xd = img_at(c, k) ? 24'(addr_at(c, k)) : c.bg;
    end
    if (e == 0) last = 0;
    km = e - 1;
    xr = (km >= 0) && img_at(c, km);
    if (xr) last = addr_at(c, km);
    cmp(nm, "hsync",       e, 32'(hs_a),  32'(xh));
    cmp(nm, "vsync",       e, 32'(vs_a),  32'(xs));
    cmp(nm, "visible",     e, 32'(vis_a), 32'(xv));
    cmp(nm, "frame_start", e, 32'(fs_a),  32'(xf));
    cmp(nm, "data_out",    e, 32'(d_a),   32'(xd));
    cmp(nm, "mem_addr",    e, 32'(ma_a),  32'(last));
    cmp(nm, "mem_rd_en",   e, 32'(re_a),  32'(xr));
    cmp(nm, "hcount",      e, 32'(hc_a),  32'(e % ht(c)));
    cmp(nm, "vcount",      e, 32'(vc_a),  32'((e / ht(c)) % vt(c)));
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (run) begin
      check_dut("dflt",  C_D, e_d, last_d, hs_d, vs_d, vis_d, fs_d, do_d, ma_d, re_d, hc_d, vc_d);
      check_dut("small", C_S, e_s, last_s, hs_s, vs_s, vis_s, fs_s, do_s, ma_s, re_s, hc_s, vc_s);
      check_dut("bg",    C_B, e_d, last_b, hs_b, vs_b, vis_b, fs_b, do_b, ma_b, re_b, hc_b, vc_b);
    end
  end

  task automatic wait_d(input int t);
    while (e_d < t) @(negedge clk);
  endtask

  task automatic wait_s(input int t);
    while (e_s < t) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_d = 0; last_s = 0; last_b = 0;
    rst_n  = 1'b0;
    rst_s  = 1'b0;
    run    = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    cmp("lit", "rst_hsync",   0, 32'(hs_d),  32'd1);
    cmp("lit", "rst_vsync",   0, 32'(vs_d),  32'd1);
    cmp("lit", "rst_visible", 0, 32'(vis_d), 32'd0);
    cmp("lit", "rst_data",    0, 32'(do_d),  32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    rst_s = 1'b1;

    wait_d(2);    cmp("lit", "fs_early",       e_d, 32'(fs_d),  32'd0);
    wait_d(3);    cmp("lit", "fs_first",       e_d, 32'(fs_d),  32'd1);
                  cmp("lit", "vis_first",      e_d, 32'(vis_d), 32'd1);
    wait_d(5);    cmp("lit", "data_px2",       e_d, 32'(do_d),  32'd1);
    wait_d(85);   cmp("lit", "bg_rd_en_off",   e_d, 32'(re_b),  32'd0);
    wait_d(87);   cmp("lit", "bg_colour",      e_d, 32'(do_b),  32'h00FF00);
    wait_d(95);   cmp("lit", "bg_blank_data",  e_d, 32'(do_b),  32'd0);
                  cmp("lit", "bg_blank_vis",   e_d, 32'(vis_b), 32'd0);
    wait_d(280);  cmp("lit", "small_last_addr", e_d, 32'(ma_s), 32'd47);
    wait_d(282);  cmp("lit", "small_last_data", e_d, 32'(do_s), 32'd47);
    wait_d(314);  cmp("lit", "vsync_before",   e_d, 32'(vs_s),  32'd1);
    wait_d(315);  cmp("lit", "vsync_fall",     e_d, 32'(vs_s),  32'd0);
    wait_d(362);  cmp("lit", "vsync_end",      e_d, 32'(vs_s),  32'd0);
    wait_d(363);  cmp("lit", "vsync_rise",     e_d, 32'(vs_s),  32'd1);
    wait_d(385);  cmp("lit", "frame2_addr",    e_d, 32'(ma_s),  32'd0);
    wait_d(387);  cmp("lit", "frame2_fs",      e_d, 32'(fs_s),  32'd1);
    wait_d(658);  cmp("lit", "hsync_before",   e_d, 32'(hs_d),  32'd1);
    wait_d(659);  cmp("lit", "hsync_fall",     e_d, 32'(hs_d),  32'd0);

    // Mid-frame reset of the reduced instance while its vsync pulse is low.
    wait_d(704);
    @(posedge clk); #3;
    rst_s = 1'b0;
    @(negedge clk);
    cmp("lit", "midrst_vsync",   e_s, 32'(vs_s),  32'd1);
    cmp("lit", "midrst_hsync",   e_s, 32'(hs_s),  32'd1);
    cmp("lit", "midrst_visible", e_s, 32'(vis_s), 32'd0);
    cmp("lit", "midrst_hcount",  e_s, 32'(hc_s),  32'd0);
    repeat (3) @(posedge clk); #3;
    rst_s = 1'b1;
    wait_s(2);    cmp("lit", "restart_fs_early", e_s, 32'(fs_s), 32'd0);
    wait_s(3);    cmp("lit", "restart_fs",       e_s, 32'(fs_s), 32'd1);

    wait_d(801);  cmp("lit", "line1_addr", e_d, 32'(ma_d), 32'd0);
    wait_d(1601); cmp("lit", "line2_addr", e_d, 32'(ma_d), 32'd320);
    wait_d(1700);
    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Pixel source for the dithering stage in the VGA serial display path.
- Generates 640x480@60 VGA timing and reads a frame-buffer BRAM filled by the serial receiver. The stored image is shown at 2x scale from the top-left corner.
- Outputs a 24-bit {B,G,R} pixel plus a `visible` flag, aligned so they connect directly to the dithering stage's `data_in` and `visible`. `hsync` and `vsync` carry the same alignment.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_VISIBLE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch
- IMG_W, 320, stored image width in pixels (displayed 2*IMG_W wide)
- IMG_H, 240, stored image height in lines (displayed 2*IMG_H tall)
- MEM_LAT, 2, BRAM read latency in clk cycles, legal range 1..4
- ADDR_W, 17, frame-buffer address width
- BG_COLOR, 24'h000000, colour for visible pixels outside the image area

Ports:
- clk  in  1  pixel clock, 25 MHz
- rst  in  1  asynchronous, active-low reset
- mem_addr  out  ADDR_W  frame-buffer read address
- mem_rd_en  out  1  read strobe, high when mem_addr is valid
- mem_data  in  24  BRAM read data, {B,G,R}, valid MEM_LAT cycles after mem_addr/mem_rd_en
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- visible  out  1  pixel is in the 640x480 active area
- data_out  out  24  pixel colour {B,G,R}
- frame_start  out  1  one-cycle pulse aligned with pixel (0,0)
- hcount  out  10  raw horizontal counter, undelayed
- vcount  out  10  raw vertical counter, undelayed

Behaviour:
- Counters:
  - hc runs 0..HT-1, where HT = 800.
  - vc runs 0..VT-1, where VT = 525; it increments when hc wraps.
  - Both wrap to 0 together at (HT-1, VT-1).
  - hcount = hc and vcount = vc.
- Raw timing at counter time:
  - vis_r = (hc < 640) && (vc < 480).
  - hs_r low for hc in 656..751; vs_r low for vc in 490..491.
  - img_r = (hc < 2*IMG_W) && (vc < 2*IMG_H).
- Address generation uses no multiplier:
  - col = hc >> 1.
  - row_base is a register that starts at 0 each frame.
  - row_base += IMG_W when hc wraps and vc is odd and vc < 2*IMG_H. It resets to 0 at vc wrap.
  - mem_addr = row_base + col is registered, so it appears 1 cycle after the counter state.
  - mem_rd_en = img_r, registered the same way.
  - Outside the image area, mem_addr holds its last value and mem_rd_en = 0.
- Pipeline: PIPE = MEM_LAT + 1 cycles.
  - vis_r, hs_r, vs_r, img_r and the frame-start condition (hc==0 && vc==0) each pass through a PIPE-deep shift register.
  - Output registers are aligned so that mem_data for a pixel and that pixel's delayed flags coincide.
- data_out:
  - data_out = mem_data when the delayed img and vis flags are both 1.
  - data_out = BG_COLOR when delayed vis = 1 and delayed img = 0.
  - data_out = 24'd0 when delayed vis = 0.
  - data_out is registered together with the flags.
- Total latency from counter state to outputs is PIPE cycles. hsync, vsync, visible, data_out and frame_start share the same latency.
- Reset (rst = 0, asynchronous):
  - hc = vc = 0, row_base = 0.
  - mem_addr = 0, mem_rd_en = 0.
  - All pipeline stages reset to inactive: vis = 0, hs = 1, vs = 1, img = 0, fs = 0.
  - Outputs: hsync = 1, vsync = 1, visible = 0, data_out = 0, frame_start = 0.
- After reset deasserts, the counters are at (0,0) on the first rising edge. visible and frame_start first assert PIPE cycles later.
- Reset mid-frame aborts the frame. Timing restarts cleanly at (0,0) with no partial sync pulse on the output.
- If IMG_W*IMG_H > 2^ADDR_W, the configuration is illegal and the design raises an elaboration-time assertion.

Test Plan:
- Reset values: hold rst = 0 for 5 cycles, then release. Required: hsync = 1, vsync = 1, visible = 0, data_out = 0 while in reset. First frame_start appears exactly PIPE = 3 cycles after release (MEM_LAT = 2).
- Line and frame timing:
  - hsync period is 800 cycles with a 96-cycle low pulse.
  - hsync falls 656 cycles after the visible rising edge of the same line.
  - visible is high for 640 consecutive cycles per line, on 480 lines.
  - vsync period is 420000 cycles with a low width of 1600 cycles.
- Address sequence (IMG_W = 320, IMG_H = 240):
  - Line 0: mem_addr = 0,0,1,1,...,319,319.
  - Line 1 repeats line 0.
  - Line 2 starts at 320.
  - Pixel (639,479) reads 76799; the next frame restarts at 0.
- Alignment: the BRAM model returns {7'b0, addr}, MEM_LAT = 2. Required: at every output cycle with visible = 1, data_out equals the address computed for that pixel's (hc>>1, vc>>1).
- Background: IMG_W = 200, IMG_H = 100, BG_COLOR = 24'h00FF00. Required:
  - Pixels with hc >= 400 or vc >= 200 output 24'h00FF00 while visible = 1.
  - mem_rd_en = 0 at those pixels.
  - Blanking outputs 0.
- Mid-frame reset: assert rst at (300,250). Required: outputs return to reset values immediately, and timing restarts from (0,0) after release with correct 800/525 periods.
